// File: rtl/tm1638_frame_tx_if.sv
// Panel-side bundle for the TM1638 frame transmitter: frame content and enable in,
// 3-wire serial lines and frame status out.
interface tm1638_frame_tx_if;
   logic        en;
   logic [7:0]  led;
   logic [31:0] digits;
   logic        tm_clk;
   logic        tm_stb;
   logic        tm_dio;
   logic        busy;
   logic        frame_done;

   modport master (
      output en, led, digits,
      input  tm_clk, tm_stb, tm_dio, busy, frame_done
   );

   modport slave (
      input  en, led, digits,
      output tm_clk, tm_stb, tm_dio, busy, frame_done
   );
endinterface

// File: rtl/tm1638_frame_tx.sv
// Continuously refreshes a TM1638 panel (write-only): data-set command, address plus
// 16 display bytes, then display-control, all paced by a tick divider.
//
// state | meaning
// IDLE  | waiting for a tick with en=1 to snapshot led/digits
// CMD1  | data-set command 0x40 (auto-increment write)
// GAP1  | one tick with STB high
// CMD2  | address 0xC0 followed by 16 display bytes
// GAP2  | one tick with STB high
// CMD3  | display-control 0x88|BRIGHT; frame_done on its STB rise
// FGAP  | GAP_TICKS ticks with STB high before the next frame
module tm1638_frame_tx #(
   parameter int CLK_DIV   = 50,
   parameter int BRIGHT    = 7,
   parameter int GAP_TICKS = 2
) (
   input logic              clk_50M,
   input logic              rs,
   tm1638_frame_tx_if.slave bus
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS - 1);
   localparam logic [7:0]    CMD3_BYTE = 8'h88 | {5'd0, 3'(BRIGHT)};

   typedef enum logic [2:0] {S_IDLE, S_CMD1, S_GAP1, S_CMD2, S_GAP2, S_CMD3, S_FGAP} state_t;
   typedef enum logic [1:0] {P_FALL, P_BIT, P_RISE} phase_t;

   state_t        state_q, state_d;
   phase_t        sub_q, sub_d;
   logic [DW-1:0] div_q;
   logic [2:0]    bit_q, bit_d;
   logic          half_q, half_d;
   logic [4:0]    byte_q, byte_d;
   logic [7:0]    sh_q, sh_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    led_q, led_d;
   logic [31:0]   dig_q, dig_d;
   logic          stb_q, stb_d, clk_q, clk_d, dio_q, dio_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic          tick;
   logic [4:0]    last_byte;

   function automatic logic [7:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 8'h3F;
         4'h1: seg7 = 8'h06;
         4'h2: seg7 = 8'h5B;
         4'h3: seg7 = 8'h4F;
         4'h4: seg7 = 8'h66;
         4'h5: seg7 = 8'h6D;
         4'h6: seg7 = 8'h7D;
         4'h7: seg7 = 8'h07;
         4'h8: seg7 = 8'h7F;
         4'h9: seg7 = 8'h6F;
         4'hA: seg7 = 8'h77;
         4'hB: seg7 = 8'h7C;
         4'hC: seg7 = 8'h39;
         4'hD: seg7 = 8'h5E;
         4'hE: seg7 = 8'h79;
         default: seg7 = 8'h71;
      endcase
   endfunction

   // CMD2 byte idx (1..16): odd addresses carry LED i, even addresses carry digit i.
   function automatic logic [7:0] cmd2_byte(input logic [4:0] idx, input logic [7:0] leds,
                                            input logic [31:0] digs);
      logic [3:0] j;
      j = 4'(idx - 5'd1);
      if (j[0]) cmd2_byte = {7'b0, leds[j[3:1]]};
      else      cmd2_byte = seg7(digs[{j[3:1], 2'b00} +: 4]);
   endfunction

   assign tick      = (div_q == DW'(CLK_DIV - 1));
   assign last_byte = (state_q == S_CMD2) ? 5'd16 : 5'd0;

   always_ff @(posedge clk_50M) begin
      if (rs) begin
         state_q <= S_IDLE;
         sub_q   <= P_FALL;
         div_q   <= '0;
         bit_q   <= '0;
         half_q  <= 1'b0;
         byte_q  <= '0;
         sh_q    <= '0;
         gap_q   <= '0;
         led_q   <= '0;
         dig_q   <= '0;
         stb_q   <= 1'b1;
         clk_q   <= 1'b1;
         dio_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         div_q   <= tick ? '0 : div_q + 1'b1;
         bit_q   <= bit_d;
         half_q  <= half_d;
         byte_q  <= byte_d;
         sh_q    <= sh_d;
         gap_q   <= gap_d;
         led_q   <= led_d;
         dig_q   <= dig_d;
         stb_q   <= stb_d;
         clk_q   <= clk_d;
         dio_q   <= dio_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            S_IDLE: if (bus.en) state_d = S_CMD1;
            S_CMD1: if (sub_q == P_RISE) state_d = S_GAP1;
            S_GAP1: state_d = S_CMD2;
            S_CMD2: if (sub_q == P_RISE) state_d = S_GAP2;
            S_GAP2: state_d = S_CMD3;
            S_CMD3: if (sub_q == P_RISE) state_d = S_FGAP;
            S_FGAP: if (gap_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      sub_d  = sub_q;
      bit_d  = bit_q;
      half_d = half_q;
      byte_d = byte_q;
      sh_d   = sh_q;
      gap_d  = gap_q;
      led_d  = led_q;
      dig_d  = dig_q;
      stb_d  = stb_q;
      clk_d  = clk_q;
      dio_d  = dio_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (bus.en) begin
                  led_d  = bus.led;
                  dig_d  = bus.digits;
                  busy_d = 1'b1;
                  sub_d  = P_FALL;
               end
            end
            S_GAP1, S_GAP2: sub_d = P_FALL;
            S_FGAP: if (gap_q != '0) gap_d = gap_q - 1'b1;
            S_CMD1, S_CMD2, S_CMD3: begin
               case (sub_q)
                  P_FALL: begin
                     stb_d  = 1'b0;
                     sub_d  = P_BIT;
                     bit_d  = '0;
                     half_d = 1'b0;
                     byte_d = '0;
                     case (state_q)
                        S_CMD1:  sh_d = 8'h40;
                        S_CMD2:  sh_d = 8'hC0;
                        default: sh_d = CMD3_BYTE;
                     endcase
                  end
                  P_BIT: begin
                     if (!half_q) begin
                        clk_d  = 1'b0;
                        dio_d  = sh_q[0];
                        half_d = 1'b1;
                     end else begin
                        clk_d  = 1'b1;
                        half_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                        sh_d   = sh_q >> 1;
                        if (bit_q == 3'd7) begin
                           if (byte_q == last_byte) begin
                              sub_d = P_RISE;
                           end else begin
                              byte_d = byte_q + 5'd1;
                              sh_d   = cmd2_byte(byte_q + 5'd1, led_q, dig_q);
                           end
                        end
                     end
                  end
                  default: begin
                     stb_d = 1'b1;
                     dio_d = 1'b1;
                     if (state_q == S_CMD3) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        gap_d  = GAP_LOAD;
                     end
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   assign bus.tm_clk     = clk_q;
   assign bus.tm_stb     = stb_q;
   assign bus.tm_dio     = dio_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_tm1638_frame_tx.sv
// Scoreboard bench for tm1638_frame_tx: a monitor decodes serial bytes and frame
// timing while the stimulus process queues hand-computed frames.
module tb_tm1638_frame_tx;

   localparam int CLK_DIV   = 2;
   localparam int FRAME_CYC = 312 * CLK_DIV;

   typedef logic [7:0] frame_t [19];

   localparam frame_t F_T2 = '{8'h40, 8'hC0,
      8'h07, 8'h01, 8'h07, 8'h00, 8'h07, 8'h01, 8'h07, 8'h00,
      8'h07, 8'h00, 8'h07, 8'h00, 8'h07, 8'h00, 8'h07, 8'h00, 8'h8F};
   localparam frame_t F_T4 = '{8'h40, 8'hC0,
      8'h7F, 8'h00, 8'h6F, 8'h01, 8'h77, 8'h00, 8'h7C, 8'h00,
      8'h39, 8'h00, 8'h5E, 8'h00, 8'h79, 8'h00, 8'h71, 8'h01, 8'h8F};
   localparam frame_t F_T5A = '{8'h40, 8'hC0,
      8'h07, 8'h01, 8'h7D, 8'h01, 8'h6D, 8'h01, 8'h66, 8'h01,
      8'h4F, 8'h00, 8'h5B, 8'h00, 8'h06, 8'h00, 8'h3F, 8'h00, 8'h8F};
   localparam frame_t F_T5B = '{8'h40, 8'hC0,
      8'h3F, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00,
      8'h3F, 8'h01, 8'h3F, 8'h01, 8'h3F, 8'h01, 8'h3F, 8'h01, 8'h8F};

   logic clk_50M = 1'b0;
   logic rs;
   tm1638_frame_tx_if bus ();

   tm1638_frame_tx #(.CLK_DIV(CLK_DIV), .BRIGHT(7), .GAP_TICKS(2)) dut (
      .clk_50M (clk_50M),
      .rs      (rs),
      .bus     (bus)
   );

   always #5 clk_50M = ~clk_50M;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   int   cyc = 0, start_cyc = 0, dio_age = 0, high_cnt = 1000;
   int   bitcnt = 0, bytes_in_frame = 0, stb_falls = 0;
   logic prev_clk = 1'b1, prev_stb = 1'b1, prev_dio = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;
   logic [7:0] shreg = '0, exp_b;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   task automatic push_frame(input frame_t f);
      foreach (f[i]) exp_q.push_back(f[i]);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      do begin
         @(negedge clk_50M);
         n++;
      end while (!bus.frame_done && n < 3 * FRAME_CYC);
      check({name, "_done_seen"}, bus.frame_done, 1'b1);
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!bus.busy && n < 200) begin
         @(negedge clk_50M);
         n++;
      end
      check({name, "_busy_seen"}, bus.busy, 1'b1);
   endtask

   // monitor: serial byte decode, scoreboard pops and timing checks
   initial begin
      forever begin
         @(negedge clk_50M);
         cyc++;
         if (bus.tm_dio !== prev_dio) dio_age = 0;
         else dio_age++;
         if (prev_stb && !bus.tm_stb) begin
            stb_falls++;
            check("stb_high_gap", 32'(high_cnt >= 2 * CLK_DIV), 1);
            high_cnt = 0;
         end
         if (bus.tm_stb) begin
            bitcnt = 0;
            high_cnt++;
         end
         if (!bus.tm_stb && !prev_clk && bus.tm_clk) begin
            check("dio_setup", 32'(dio_age >= CLK_DIV), 1);
            shreg = {bus.tm_dio, shreg[7:1]};
            bitcnt++;
            if (bitcnt == 8) begin
               bitcnt = 0;
               bytes_in_frame++;
               if (exp_q.size() == 0) begin
                  check("unexpected_byte", shreg, 8'hxx);
               end else begin
                  exp_b = exp_q.pop_front();
                  check("frame_byte", shreg, exp_b);
               end
            end
         end
         if (bus.busy && !prev_busy) begin
            start_cyc = cyc;
            bytes_in_frame = 0;
         end
         if (prev_done) check("done_one_clock", bus.frame_done, 1'b0);
         if (bus.frame_done) begin
            check("frame_length", cyc - start_cyc, FRAME_CYC);
            check("frame_bytes", bytes_in_frame, 19);
            check("busy_clear_at_done", bus.busy, 1'b0);
         end
         prev_clk  = bus.tm_clk;
         prev_stb  = bus.tm_stb;
         prev_dio  = bus.tm_dio;
         prev_busy = bus.busy;
         prev_done = bus.frame_done;
      end
   end

   initial begin
      rs = 1'b1;
      bus.en = 1'b0;
      bus.led = '0;
      bus.digits = '0;
      repeat (4) @(negedge clk_50M);
      rs = 1'b0;
      @(negedge clk_50M);
      check("rst_stb", bus.tm_stb, 1'b1);
      check("rst_clk", bus.tm_clk, 1'b1);
      check("rst_dio", bus.tm_dio, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.frame_done, 1'b0);
      repeat (1000) @(negedge clk_50M);
      check("idle_no_stb", stb_falls, 0);
      check("idle_no_busy", bus.busy, 1'b0);

      // basic frame
      bus.led = 8'b0000_0101;
      bus.digits = 32'h7777_7777;
      push_frame(F_T2);
      bus.en = 1'b1;
      wait_done("t2");
      bus.en = 1'b0;

      // all upper hex digits
      repeat (20) @(negedge clk_50M);
      bus.led = 8'h82;
      bus.digits = 32'hFEDC_BA98;
      push_frame(F_T4);
      bus.en = 1'b1;
      wait_done("t4");
      bus.en = 1'b0;

      // inputs change mid-CMD2; en drops mid-frame on the second frame
      repeat (20) @(negedge clk_50M);
      bus.led = 8'h0F;
      bus.digits = 32'h0123_4567;
      push_frame(F_T5A);
      push_frame(F_T5B);
      bus.en = 1'b1;
      wait_busy("t5a");
      repeat (100 * CLK_DIV) @(negedge clk_50M);
      bus.led = 8'hF0;
      bus.digits = 32'h0000_0000;
      wait_done("t5a");
      @(negedge clk_50M);
      wait_busy("t5b");
      repeat (150 * CLK_DIV) @(negedge clk_50M);
      bus.en = 1'b0;
      wait_done("t5b");

      // reset mid-CMD2 aborts the frame; a fresh frame follows
      repeat (20) @(negedge clk_50M);
      bus.led = 8'b0000_0101;
      bus.digits = 32'h7777_7777;
      push_frame(F_T2);
      bus.en = 1'b1;
      wait_busy("t6");
      repeat (150 * CLK_DIV) @(negedge clk_50M);
      rs = 1'b1;
      @(negedge clk_50M);
      check("abort_stb", bus.tm_stb, 1'b1);
      check("abort_clk", bus.tm_clk, 1'b1);
      check("abort_busy", bus.busy, 1'b0);
      exp_q.delete();
      push_frame(F_T2);
      rs = 1'b0;
      wait_done("t6");
      bus.en = 1'b0;

      repeat (20) @(negedge clk_50M);
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tm1638_frame_tx.md
Name: tm1638_frame_tx

Overview:
Downstream serial stage for the LED/7-segment panel. It takes an 8-bit LED pattern (the btn-selected sang-dan/tat-dan result) and eight 4-bit hex digits. It continuously refreshes a TM1638 module over its 3-wire interface (STB/CLK/DIO), write-only. Each frame snapshots the inputs and sends three commands: data-set, address plus 16 display bytes, and display-control.

Parameters:
CLK_DIV, 50, system clocks per tick; one serial bit takes 2 ticks (500 kHz at 50 MHz).
BRIGHT, 7, 3-bit brightness; display-control byte = 8'h88 | BRIGHT.
GAP_TICKS, 2, ticks with STB high between frames (minimum 1).

Ports:
clk_50M  in  1  system clock; all logic on its rising edge.
rs  in  1  synchronous active-high reset.
en  in  1  frames start only while en=1.
led  in  8  LED pattern; led[i] drives LED i.
digits  in  32  digit i = digits[4i+3:4i]; digit 0 is leftmost.
tm_clk  out  1  TM1638 CLK; idles high.
tm_stb  out  1  TM1638 STB, active low.
tm_dio  out  1  TM1638 DIO, LSB first; must be stable before tm_clk rises.
busy  out  1  high from frame start until frame_done.
frame_done  out  1  one-clock pulse at the end of each frame.

Behaviour:
- Reset (rs=1 at an edge): tm_stb=1, tm_clk=1, tm_dio=1, busy=0, frame_done=0, divider=0, state=IDLE. Reset overrides everything, including mid-frame; the frame is aborted and no partial resume occurs.
- Divider: counts 0..CLK_DIV-1. tick=1 in the cycle the count equals CLK_DIV-1. All output changes occur only on tick cycles, except reset and the frame_done/busy deassert.
- IDLE: on a tick with en=1, latch led and digits into a frame buffer, set busy=1, and go to CMD. Input changes after the latch do not affect the frame.
- A command segment with N bytes:
  - 1 tick: tm_stb falls to 0.
  - Per bit, LSB first: tick 1 sets tm_clk=0 and tm_dio=bit; tick 2 sets tm_clk=1.
  - 1 tick after the last bit: tm_stb rises to 1. tm_dio returns to 1.
  - Segment length = 2 + 16N ticks.
- Frame sequence:
  1. CMD1: N=1, byte 8'h40 (write, auto-increment). 18 ticks.
  2. Gap: 1 tick, tm_stb high.
  3. CMD2: N=17. Byte 8'hC0, then for i=0..7 in order: seg(digit i) at address 2i, then {7'b0, led[i]} at address 2i+1. 274 ticks.
  4. Gap: 1 tick.
  5. CMD3: N=1, byte 8'h88|BRIGHT. 18 ticks. On its STB-rise tick, pulse frame_done=1 for one clock and clear busy.
  6. FRAME_GAP: GAP_TICKS ticks, then return to IDLE (en re-sampled on the next tick).
- Frame length from start to frame_done = 312 ticks.
- en falling mid-frame does not abort; the current frame completes.
- seg() mapping, common-cathode {dp,g,f,e,d,c,b,a}, dp=0: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Byte and bit counters must not wrap into the next command. 17-byte accounting in CMD2 is exact: 16 data bytes, then STB rise.
- Suggested states: IDLE, CMD1, GAP1, CMD2, GAP2, CMD3, FGAP. A shared byte shifter, a bit counter (0-7, with phase bit) and a byte index (0-16).

Test Plan:
1. Reset with CLK_DIV=2 -> all outputs at their reset values; no tm_stb activity while en=0 for 1000 clocks.
2. en=1, led=8'b00000101, digits=32'h77777777 -> bytes decoded on tm_clk rising edges while tm_stb=0: 40 | C0 07 01 07 00 07 01 07 00 07 00 07 00 07 00 07 00 | 8F.
3. Timing check -> tm_dio is constant for one full tick before each tm_clk rise. tm_stb is high for at least 2 consecutive ticks between commands. frame_done occurs exactly 312 ticks after tm_stb first falls minus one tick, i.e. measured from the start tick.
4. digits=32'hFEDCBA98 -> segment bytes in address order 7F 6F 77 7C 39 5E 79 71.
5. Change led and digits during CMD2 -> the current frame still sends the latched values; the next frame sends the new values.
6. Assert rs mid-CMD2 for one clock -> next clock tm_stb=1, tm_clk=1, busy=0. After release with en=1, a fresh frame starts with byte 8'h40.
